// File: rtl/tank_ctrl_multi.sv
// tank_ctrl_multi
//   Multi-tank water-level controller. Each tank runs its own DRAIN/FILL/FAULT
//   state machine, with hysteresis between a low-level and a high-level sensor.
//   Minimum on/off times prevent short-cycling of the pump. A fill timeout and
//   sensor-inconsistency detection force a tank into FAULT, and a per-tank
//   clear acknowledges the fault. A shared fixed-priority arbiter caps how many
//   pumps may run at the same time; the lowest tank index wins.
//
// Ports
//   clk        : clock
//   rst        : synchronous, active-high reset
//   a          : per tank, level above the low threshold
//   b          : per tank, level above the high threshold
//   fault_clr  : per tank, fault acknowledge
//   s          : per tank, fill/pump enable (state == FILL)
//   fault      : per tank, fault flag (state == FAULT)
//   active_cnt : number of tanks currently in FILL
//
// Parameter constraints: NUM_TANKS >= 1, 1 <= MAX_ACTIVE <= NUM_TANKS,
// MIN_ON >= 1, MIN_OFF >= 1, FILL_TIMEOUT > MIN_ON.
module tank_ctrl_multi #(
  parameter int NUM_TANKS    = 4,
  parameter int MAX_ACTIVE   = 2,
  parameter int MIN_ON       = 4,
  parameter int MIN_OFF      = 4,
  parameter int FILL_TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_TANKS-1:0]               a,
  input  logic [NUM_TANKS-1:0]               b,
  input  logic [NUM_TANKS-1:0]               fault_clr,
  output logic [NUM_TANKS-1:0]               s,
  output logic [NUM_TANKS-1:0]               fault,
  output logic [$clog2(NUM_TANKS+1)-1:0]     active_cnt
);

  localparam int T_MAX_ONOFF = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int T_MAX       = (FILL_TIMEOUT > T_MAX_ONOFF) ? FILL_TIMEOUT : T_MAX_ONOFF;
  localparam int TW          = $clog2(T_MAX + 1);
  localparam int CW          = $clog2(NUM_TANKS + 1);

  localparam logic [TW-1:0] ON_LAST  = TW'(MIN_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(MIN_OFF - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0] T_SAT    = '1;

  typedef enum logic [1:0] {
    DRAIN = 2'd0,
    FILL  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t              state     [NUM_TANKS];
  state_t              state_nxt [NUM_TANKS];
  logic [TW-1:0]       timer     [NUM_TANKS];
  logic [NUM_TANKS-1:0] sf;
  logic [NUM_TANKS-1:0] req;
  logic [NUM_TANKS-1:0] grant;

  // State and timer registers. The timer restarts at 0 whenever the state
  // changes and otherwise counts up, saturating. A waiting request therefore
  // keeps its "minimum off time met" status indefinitely.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TANKS; i++) begin
        state[i] <= DRAIN;
        timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TANKS; i++) begin
        state[i] <= state_nxt[i];
        if (state_nxt[i] != state[i]) begin
          timer[i] <= '0;
        end else if (timer[i] != T_SAT) begin
          timer[i] <= timer[i] + TW'(1);
        end
      end
    end
  end

  // Fixed-priority arbitration. A tank is granted only if the tanks already in
  // FILL, plus every lower-index requester, leave room under MAX_ACTIVE. The
  // count uses the registered FILL population, so a tank leaving FILL this
  // cycle still holds its slot until the next edge.
  always_comb begin
    logic [CW:0] pending;
    sf      = b & ~a;
    req     = '0;
    grant   = '0;
    pending = '0;
    for (int i = 0; i < NUM_TANKS; i++) begin
      req[i] = (state[i] == DRAIN) && !a[i] && !sf[i] && (timer[i] >= OFF_LAST);
    end
    for (int i = 0; i < NUM_TANKS; i++) begin
      grant[i] = req[i] && (({1'b0, active_cnt} + pending) < (CW+1)'(MAX_ACTIVE));
      if (req[i]) begin
        pending = pending + (CW+1)'(1);
      end
    end
  end

  // Per-tank next state. A sensor fault overrides everything except FAULT
  // itself. A high level seen before the minimum on time only takes effect
  // once that minimum is reached.
  always_comb begin
    for (int i = 0; i < NUM_TANKS; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        DRAIN: begin
          if (sf[i]) begin
            state_nxt[i] = FAULT;
          end else if (grant[i]) begin
            state_nxt[i] = FILL;
          end
        end
        FILL: begin
          if (sf[i]) begin
            state_nxt[i] = FAULT;
          end else if (b[i] && (timer[i] >= ON_LAST)) begin
            state_nxt[i] = DRAIN;
          end else if (!b[i] && (timer[i] == TO_LAST)) begin
            state_nxt[i] = FAULT;
          end
        end
        FAULT: begin
          if (fault_clr[i] && !sf[i]) begin
            state_nxt[i] = DRAIN;
          end
        end
        default: state_nxt[i] = DRAIN;
      endcase
    end
  end

  // Outputs are decoded from the state registers only.
  always_comb begin
    s          = '0;
    fault      = '0;
    active_cnt = '0;
    for (int i = 0; i < NUM_TANKS; i++) begin
      s[i]     = (state[i] == FILL);
      fault[i] = (state[i] == FAULT);
      if (state[i] == FILL) begin
        active_cnt = active_cnt + CW'(1);
      end
    end
  end

endmodule
